// File: rtl/pipelined_control_unit_if.sv
// ID-stage inputs, EX-stage flags and the decoded/resolved control outputs of the control unit.
// The slave modport belongs to the control unit; the master modport belongs to the surrounding pipeline.
interface pipelined_control_unit_if #(
    parameter int ALUCTRL_W = 4
);
    logic                 id_valid;
    logic [6:0]           op;
    logic [2:0]           funct3;
    logic                 funct7_5;
    logic                 stall;
    logic                 EQ;
    logic                 LT;
    logic                 LTU;

    logic [2:0]           ImmSrc;
    logic                 ex_valid;
    logic [ALUCTRL_W-1:0] ex_ALUctrl;
    logic                 ex_ALUSrcA;
    logic                 ex_ALUSrc;
    logic                 ex_RegWrite;
    logic                 ex_MemWrite;
    logic [1:0]           ex_ResultSrc;
    logic                 ex_illegal;
    logic [1:0]           PCSrc;
    logic                 flush_id;

    modport master (
        output id_valid, op, funct3, funct7_5, stall, EQ, LT, LTU,
        input  ImmSrc, ex_valid, ex_ALUctrl, ex_ALUSrcA, ex_ALUSrc, ex_RegWrite,
               ex_MemWrite, ex_ResultSrc, ex_illegal, PCSrc, flush_id
    );

    modport slave (
        input  id_valid, op, funct3, funct7_5, stall, EQ, LT, LTU,
        output ImmSrc, ex_valid, ex_ALUctrl, ex_ALUSrcA, ex_ALUSrc, ex_RegWrite,
               ex_MemWrite, ex_ResultSrc, ex_illegal, PCSrc, flush_id
    );
endinterface

// File: rtl/pipelined_control_unit.sv
// RV32I control: ID decode into an ID/EX register, branch/jump resolution in EX.
// Latency: ex_* one cycle after ID; PCSrc/flush_id combinational from the EX slot.
// Backpressure: stall holds ID/EX; a redirect loads a bubble even while stalled.
module pipelined_control_unit #(
    parameter int ALUCTRL_W = 4,
    parameter bit EN_JUMP   = 1'b1
) (
    input logic                     clk,
    input logic                     rst_n,
    pipelined_control_unit_if.slave bus
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    typedef struct packed {
        logic                 illegal;
        logic [ALUCTRL_W-1:0] alu_ctrl;
        logic                 alu_src_a;
        logic                 alu_src;
        logic                 reg_write;
        logic                 mem_write;
        logic [1:0]           result_src;
        logic                 branch;
        logic                 jal;
        logic                 jalr;
        logic [2:0]           funct3;
    } ctrl_t;

    ctrl_t      dec;
    ctrl_t      ex;
    logic       ex_valid_q;
    logic [3:0] alu_f3;
    logic [2:0] imm_src;
    logic       taken;
    logic [1:0] pc_src;
    logic       flush;

    // funct3 -> ALU op shared by R and I-ALU; funct7_5 means SUB only for R-type
    always_comb begin
        alu_f3 = ALU_ADD;
        case (bus.funct3)
            3'b000:  alu_f3 = (bus.op == OP_R && bus.funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_f3 = ALU_SLL;
            3'b010:  alu_f3 = ALU_SLT;
            3'b011:  alu_f3 = ALU_SLTU;
            3'b100:  alu_f3 = ALU_XOR;
            3'b101:  alu_f3 = bus.funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_f3 = ALU_OR;
            3'b111:  alu_f3 = ALU_AND;
            default: alu_f3 = ALU_ADD;
        endcase
    end

    always_comb begin
        dec        = '0;
        dec.funct3 = bus.funct3;
        imm_src    = 3'b000;
        case (bus.op)
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.alu_ctrl  = ALUCTRL_W'(alu_f3);
            end
            OP_I: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = ALUCTRL_W'(alu_f3);
            end
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = 2'b01;
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                imm_src       = 3'b001;
            end
            OP_BR: begin
                dec.alu_ctrl = ALUCTRL_W'(ALU_SUB);
                imm_src      = 3'b010;
                if (bus.funct3[2:1] == 2'b01) dec.illegal = 1'b1;
                else                          dec.branch  = 1'b1;
            end
            OP_LUI: begin
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b11;
                imm_src        = 3'b011;
            end
            OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src_a = 1'b1;
                dec.alu_src   = 1'b1;
                imm_src       = 3'b011;
            end
            OP_JAL: begin
                imm_src = 3'b100;
                if (EN_JUMP) begin
                    dec.reg_write  = 1'b1;
                    dec.jal        = 1'b1;
                    dec.alu_src_a  = 1'b1;
                    dec.alu_src    = 1'b1;
                    dec.result_src = 2'b10;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_JALR: begin
                if (EN_JUMP) begin
                    dec.reg_write  = 1'b1;
                    dec.jalr       = 1'b1;
                    dec.alu_src    = 1'b1;
                    dec.result_src = 2'b10;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // redirect beats stall so the resolved branch/jump leaves EX on this edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex         <= '0;
        end else if (flush) begin
            ex_valid_q <= 1'b0;
            ex         <= '0;
        end else if (!bus.stall) begin
            ex_valid_q <= bus.id_valid;
            ex         <= bus.id_valid ? dec : '0;
        end
    end

    always_comb begin
        taken = 1'b0;
        case (ex.funct3)
            3'b000:  taken = bus.EQ;
            3'b001:  taken = !bus.EQ;
            3'b100:  taken = bus.LT;
            3'b101:  taken = !bus.LT;
            3'b110:  taken = bus.LTU;
            3'b111:  taken = !bus.LTU;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        pc_src = 2'b00;
        if (ex_valid_q) begin
            if (ex.jalr)                           pc_src = 2'b10;
            else if (ex.jal || (ex.branch && taken)) pc_src = 2'b01;
        end
    end

    assign flush = (pc_src != 2'b00);

    assign bus.ImmSrc       = imm_src;
    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_ALUctrl   = ex.alu_ctrl;
    assign bus.ex_ALUSrcA   = ex.alu_src_a;
    assign bus.ex_ALUSrc    = ex.alu_src;
    assign bus.ex_RegWrite  = ex.reg_write;
    assign bus.ex_MemWrite  = ex.mem_write;
    assign bus.ex_ResultSrc = ex.result_src;
    assign bus.ex_illegal   = ex.illegal;
    assign bus.PCSrc        = pc_src;
    assign bus.flush_id     = flush;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: vector table, hand-written pipeline sequences,
// then random traffic against an instruction-level reference model.
module tb_pipelined_control_unit;
    localparam int W = 6;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    // ALU code selected by funct3 when no funct7_5 modifier applies
    localparam int ALU_TAB [8] = '{0, 7, 5, 6, 4, 8, 3, 2};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipelined_control_unit_if #(.ALUCTRL_W(W)) bus();
    pipelined_control_unit_if #(.ALUCTRL_W(4)) bus_nj();

    assign bus_nj.id_valid = bus.id_valid;
    assign bus_nj.op       = bus.op;
    assign bus_nj.funct3   = bus.funct3;
    assign bus_nj.funct7_5 = bus.funct7_5;
    assign bus_nj.stall    = bus.stall;
    assign bus_nj.EQ       = bus.EQ;
    assign bus_nj.LT       = bus.LT;
    assign bus_nj.LTU      = bus.LTU;

    pipelined_control_unit #(.ALUCTRL_W(W), .EN_JUMP(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave));
    pipelined_control_unit #(.ALUCTRL_W(4), .EN_JUMP(1'b0)) dut_nj (
        .clk(clk), .rst_n(rst_n), .bus(bus_nj.slave));

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit         valid;
        int         alu;
        bit         srca, src, rw, mw;
        int         rs;
        bit         ill, br, jal, jalr;
        logic [2:0] f3;
    } ex_m_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f75;
        logic       iv;
        int         alu, rw, mw, rs, ill, imm;
    } vec_t;

    ex_m_t m;
    vec_t  tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ex_m_t m_zero();
        ex_m_t r;
        r.valid = 0; r.alu = 0; r.srca = 0; r.src = 0; r.rw = 0; r.mw = 0;
        r.rs = 0; r.ill = 0; r.br = 0; r.jal = 0; r.jalr = 0; r.f3 = 3'b000;
        return r;
    endfunction

    function automatic ex_m_t ref_decode(input logic [6:0] o, input logic [2:0] f3, input logic f75);
        ex_m_t r;
        r = m_zero();
        r.valid = 1;
        r.f3 = f3;
        case (o)
            OP_R:     begin r.rw = 1; r.alu = (f3 == 3'd0 && f75) ? 1 : (f3 == 3'd5 && f75) ? 9 : ALU_TAB[f3]; end
            OP_I:     begin r.rw = 1; r.src = 1; r.alu = (f3 == 3'd5 && f75) ? 9 : ALU_TAB[f3]; end
            OP_LOAD:  begin r.rw = 1; r.src = 1; r.rs = 1; end
            OP_STORE: begin r.mw = 1; r.src = 1; end
            OP_BR:    begin r.alu = 1; if (f3 == 3'd2 || f3 == 3'd3) r.ill = 1; else r.br = 1; end
            OP_LUI:   begin r.rw = 1; r.rs = 3; end
            OP_AUIPC: begin r.rw = 1; r.srca = 1; r.src = 1; end
            OP_JAL:   begin r.rw = 1; r.jal = 1; r.srca = 1; r.src = 1; r.rs = 2; end
            OP_JALR:  begin r.rw = 1; r.jalr = 1; r.src = 1; r.rs = 2; end
            default:  r.ill = 1;
        endcase
        return r;
    endfunction

    function automatic int ref_imm(input logic [6:0] o);
        if (o == OP_STORE) return 1;
        if (o == OP_BR) return 2;
        if (o == OP_LUI || o == OP_AUIPC) return 3;
        if (o == OP_JAL) return 4;
        return 0;
    endfunction

    // odd funct3 negates; bit 2 picks signed/unsigned compare over equality
    function automatic int ref_pcsrc(input ex_m_t s, input logic eq, input logic lt, input logic ltu);
        logic c;
        if (!s.valid) return 0;
        if (s.jalr) return 2;
        if (s.jal) return 1;
        if (!s.br) return 0;
        c = (s.f3 >= 3'd6) ? ltu : (s.f3 >= 3'd4) ? lt : eq;
        return (c ^ s.f3[0]) ? 1 : 0;
    endfunction

    function automatic vec_t mk(input logic [6:0] o, input logic [2:0] f3, input logic f75, input logic iv,
                                input int alu, input int rw, input int mw, input int rs, input int ill, input int imm);
        vec_t v;
        v.op = o; v.f3 = f3; v.f75 = f75; v.iv = iv;
        v.alu = alu; v.rw = rw; v.mw = mw; v.rs = rs; v.ill = ill; v.imm = imm;
        return v;
    endfunction

    task automatic drive(input logic iv, input logic [6:0] o, input logic [2:0] f3, input logic f75,
                         input logic st, input logic eq, input logic lt, input logic ltu);
        bus.id_valid = iv; bus.op = o; bus.funct3 = f3; bus.funct7_5 = f75;
        bus.stall = st; bus.EQ = eq; bus.LT = lt; bus.LTU = ltu;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        int pc;
        pc = ref_pcsrc(m, bus.EQ, bus.LT, bus.LTU);
        chk({tag, ".valid"},  32'(bus.ex_valid),     32'(m.valid));
        chk({tag, ".alu"},    32'(bus.ex_ALUctrl),   m.alu);
        chk({tag, ".srca"},   32'(bus.ex_ALUSrcA),   32'(m.srca));
        chk({tag, ".src"},    32'(bus.ex_ALUSrc),    32'(m.src));
        chk({tag, ".rw"},     32'(bus.ex_RegWrite),  32'(m.rw));
        chk({tag, ".mw"},     32'(bus.ex_MemWrite),  32'(m.mw));
        chk({tag, ".rs"},     32'(bus.ex_ResultSrc), m.rs);
        chk({tag, ".ill"},    32'(bus.ex_illegal),   32'(m.ill));
        chk({tag, ".pcsrc"},  32'(bus.PCSrc),        pc);
        chk({tag, ".flush"},  32'(bus.flush_id),     (pc != 0) ? 1 : 0);
        chk({tag, ".imm"},    32'(bus.ImmSrc),       ref_imm(bus.op));
    endtask

    task automatic step_model();
        int pc;
        @(posedge clk);
        pc = ref_pcsrc(m, bus.EQ, bus.LT, bus.LTU);
        if (pc != 0)            m = m_zero();
        else if (!bus.stall)    m = bus.id_valid ? ref_decode(bus.op, bus.funct3, bus.funct7_5) : m_zero();
    endtask

    initial begin
        logic [6:0] ops [9];
        logic [2:0] br_f3 [6];
        bit t100 [6];
        bit t011 [6];
        bit tk;
        ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
        br_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        t100 = '{1, 0, 0, 1, 0, 1};
        t011 = '{0, 1, 1, 0, 1, 0};

        //        op        f3    f75   iv    alu rw mw rs ill imm
        tbl.push_back(mk(OP_R,     3'd0, 1'b0, 1'b1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_R,     3'd0, 1'b1, 1'b1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_R,     3'd5, 1'b1, 1'b1, 9, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_R,     3'd5, 1'b0, 1'b1, 8, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_R,     3'd3, 1'b0, 1'b1, 6, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_R,     3'd7, 1'b1, 1'b1, 2, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_I,     3'd5, 1'b1, 1'b1, 9, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_I,     3'd0, 1'b1, 1'b1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_I,     3'd6, 1'b0, 1'b1, 3, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_I,     3'd4, 1'b0, 1'b1, 4, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_I,     3'd1, 1'b0, 1'b1, 7, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_I,     3'd2, 1'b0, 1'b1, 5, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_LOAD,  3'd2, 1'b0, 1'b1, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(OP_STORE, 3'd2, 1'b1, 1'b1, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(OP_LUI,   3'd0, 1'b0, 1'b1, 0, 1, 0, 3, 0, 3));
        tbl.push_back(mk(OP_AUIPC, 3'd0, 1'b0, 1'b1, 0, 1, 0, 0, 0, 3));
        tbl.push_back(mk(7'h7F,    3'd0, 1'b0, 1'b1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(OP_STORE, 3'd2, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1));

        // reset held with a live R-type in ID
        rst_n = 1'b0;
        drive(1, OP_R, 3'd0, 1'b0, 0, 0, 0, 0);
        tick(); tick();
        chk("rst.valid", 32'(bus.ex_valid), 0);
        chk("rst.rw",    32'(bus.ex_RegWrite), 0);
        chk("rst.mw",    32'(bus.ex_MemWrite), 0);
        chk("rst.alu",   32'(bus.ex_ALUctrl), 0);
        chk("rst.rs",    32'(bus.ex_ResultSrc), 0);
        chk("rst.ill",   32'(bus.ex_illegal), 0);
        chk("rst.pcsrc", 32'(bus.PCSrc), 0);
        chk("rst.flush", 32'(bus.flush_id), 0);
        rst_n = 1'b1;
        tick();
        chk("rel.valid", 32'(bus.ex_valid), 1);
        chk("rel.rw",    32'(bus.ex_RegWrite), 1);
        chk("rel.alu",   32'(bus.ex_ALUctrl), 0);

        foreach (tbl[i]) begin
            drive(tbl[i].iv, tbl[i].op, tbl[i].f3, tbl[i].f75, 0, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("vec%0d.imm", i), 32'(bus.ImmSrc), tbl[i].imm);
            tick();
            chk($sformatf("vec%0d.valid", i), 32'(bus.ex_valid), 32'(tbl[i].iv));
            chk($sformatf("vec%0d.alu", i),   32'(bus.ex_ALUctrl), tbl[i].alu);
            chk($sformatf("vec%0d.rw", i),    32'(bus.ex_RegWrite), tbl[i].rw);
            chk($sformatf("vec%0d.mw", i),    32'(bus.ex_MemWrite), tbl[i].mw);
            chk($sformatf("vec%0d.rs", i),    32'(bus.ex_ResultSrc), tbl[i].rs);
            chk($sformatf("vec%0d.ill", i),   32'(bus.ex_illegal), tbl[i].ill);
            chk($sformatf("vec%0d.pcsrc", i), 32'(bus.PCSrc), 0);
        end

        // every branch condition under two flag sets; ADD sits in ID behind it
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 6; k++) begin
                drive(1, OP_BR, br_f3[k], 1'b0, 0, 0, 0, 0);
                tick();
                if (s == 0) drive(1, OP_R, 3'd0, 1'b0, 0, 1, 0, 0);
                else        drive(1, OP_R, 3'd0, 1'b0, 0, 0, 1, 1);
                #1;
                tk = (s == 0) ? t100[k] : t011[k];
                chk($sformatf("br%0d_%0d.pcsrc", k, s), 32'(bus.PCSrc), tk ? 1 : 0);
                chk($sformatf("br%0d_%0d.flush", k, s), 32'(bus.flush_id), 32'(tk));
                tick();
                chk($sformatf("br%0d_%0d.next", k, s), 32'(bus.ex_valid), 32'(!tk));
            end
        end

        drive(1, OP_BR, 3'd2, 1'b0, 0, 1, 1, 1);
        tick();
        chk("br010.ill",   32'(bus.ex_illegal), 1);
        chk("br010.pcsrc", 32'(bus.PCSrc), 0);

        drive(1, OP_JAL, 3'd0, 1'b0, 0, 0, 0, 0);
        tick();
        drive(0, OP_R, 3'd0, 1'b0, 0, 0, 0, 0);
        #1;
        chk("jal.rs",       32'(bus.ex_ResultSrc), 2);
        chk("jal.srca",     32'(bus.ex_ALUSrcA), 1);
        chk("jal.pcsrc",    32'(bus.PCSrc), 1);
        chk("jal.flush",    32'(bus.flush_id), 1);
        chk("nj_jal.ill",   32'(bus_nj.ex_illegal), 1);
        chk("nj_jal.rw",    32'(bus_nj.ex_RegWrite), 0);
        chk("nj_jal.pcsrc", 32'(bus_nj.PCSrc), 0);
        tick();
        drive(1, OP_JALR, 3'd0, 1'b0, 0, 0, 0, 0);
        tick();
        drive(0, OP_R, 3'd0, 1'b0, 0, 0, 0, 0);
        #1;
        chk("jalr.pcsrc",    32'(bus.PCSrc), 2);
        chk("jalr.flush",    32'(bus.flush_id), 1);
        chk("jalr.rs",       32'(bus.ex_ResultSrc), 2);
        chk("nj_jalr.pcsrc", 32'(bus_nj.PCSrc), 0);
        chk("nj_jalr.ill",   32'(bus_nj.ex_illegal), 1);
        tick();

        // three stalled cycles with a different instruction waiting in ID
        drive(1, OP_I, 3'd6, 1'b0, 0, 0, 0, 0);
        tick();
        drive(1, OP_STORE, 3'd2, 1'b0, 1, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stall%0d.alu", c),   32'(bus.ex_ALUctrl), 3);
            chk($sformatf("stall%0d.src", c),   32'(bus.ex_ALUSrc), 1);
            chk($sformatf("stall%0d.mw", c),    32'(bus.ex_MemWrite), 0);
            chk($sformatf("stall%0d.valid", c), 32'(bus.ex_valid), 1);
        end
        drive(1, OP_BR, 3'd0, 1'b0, 0, 0, 0, 0);
        tick();
        drive(1, OP_R, 3'd0, 1'b0, 1, 1, 0, 0);
        #1;
        chk("stflush.pcsrc", 32'(bus.PCSrc), 1);
        tick();
        chk("stflush.valid", 32'(bus.ex_valid), 0);
        chk("stflush.rw",    32'(bus.ex_RegWrite), 0);

        drive(1, 7'h7F, 3'd0, 1'b0, 0, 0, 0, 0);
        tick();
        chk("illop.ill",   32'(bus.ex_illegal), 1);
        chk("illop.rw",    32'(bus.ex_RegWrite), 0);
        chk("illop.mw",    32'(bus.ex_MemWrite), 0);
        chk("illop.valid", 32'(bus.ex_valid), 1);
        drive(0, OP_STORE, 3'd2, 1'b0, 0, 0, 0, 0);
        tick();
        chk("bubble.valid", 32'(bus.ex_valid), 0);
        chk("bubble.mw",    32'(bus.ex_MemWrite), 0);

        // asynchronous reset between edges, then a normal load on the next edge
        drive(1, OP_R, 3'd0, 1'b0, 0, 0, 0, 0);
        tick();
        chk("async.pre", 32'(bus.ex_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async.valid", 32'(bus.ex_valid), 0);
        chk("async.rw",    32'(bus.ex_RegWrite), 0);
        rst_n = 1'b1;
        tick();
        chk("async.load.valid", 32'(bus.ex_valid), 1);
        chk("async.load.rw",    32'(bus.ex_RegWrite), 1);

        // random traffic against the reference model
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        m = m_zero();
        for (int n = 0; n < 600; n++) begin
            logic [6:0] o;
            int sel;
            sel = $urandom_range(0, 10);
            o = (sel < 9) ? ops[sel] : 7'($urandom);
            drive(($urandom_range(0, 3) != 0), o, 3'($urandom), 1'($urandom),
                  ($urandom_range(0, 4) == 0), 1'($urandom), 1'($urandom), 1'($urandom));
            @(negedge clk);
            check_all($sformatf("rnd%0d", n));
            step_model();
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
